// File: rtl/bus_host_pkg.sv
// Shared types and timing defaults for the register-bus host master.
package bus_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int MIN_STROBE_CYCLES = 3;

endpackage

// File: rtl/bus_host_timer.sv
// Loadable 4-bit down-counter; tc flags the last cycle of a timed state.
module bus_host_timer (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       tc
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign tc = (cnt == 4'd0);

endmodule

// File: rtl/bus_host_master.sv
// Host master moving 16-bit register words over an 8-bit strobed bus.
// Reads are only performed when BUS_HOST_READ_EN is defined.
module bus_host_master
  import bus_host_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_sel_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 16 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 16 ||
      STROBE_CYCLES < MIN_STROBE_CYCLES ||
      STROBE_CYCLES > 15) begin : g_bad_timing
    $error("bus_host_master: timing parameters out of range");
  end

  localparam logic [3:0] S_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] T_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic        phase, phase_nxt;
  logic        tmr_load, tmr_tc;
  logic [3:0]  tmr_val;
  logic        accept, rd_skip, on_bus;
  logic        rd_nwr_q;
  logic [3:0]  reg_q;
  logic [15:0] data_q;

`ifdef BUS_HOST_READ_EN
  assign rd_skip = 1'b0;
`else
  assign rd_skip = req_rd_nwr_i;
`endif

  assign accept = (state == IDLE) && req_valid_i;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (rd_skip) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
            phase_nxt = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = S_LD;
          end
        end
      end
      SETUP: begin
        if (tmr_tc) begin
          state_nxt = STROBE;
          tmr_load  = 1'b1;
          tmr_val   = T_LD;
        end
      end
      STROBE: begin
        if (tmr_tc) begin
          state_nxt = HOLD;
          tmr_load  = 1'b1;
          tmr_val   = H_LD;
        end
      end
      HOLD: begin
        if (tmr_tc) begin
          if (!phase) begin
            state_nxt = SETUP;
            phase_nxt = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = S_LD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state <= IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      rd_nwr_q <= 1'b0;
      reg_q    <= '0;
      data_q   <= '0;
    end else if (accept) begin
      rd_nwr_q <= req_rd_nwr_i;
      reg_q    <= req_reg_num_i;
      data_q   <= req_data_i;
    end
  end

  bus_host_timer u_timer (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .tc        (tmr_tc)
  );

`ifdef BUS_HOST_READ_EN
  logic [15:0] rd_buf, rsp_q;

  // Bytes collect in rd_buf; rsp_data_o only moves when the read completes.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      rd_buf <= '0;
      rsp_q  <= '0;
    end else if (rd_nwr_q && tmr_tc) begin
      if (state == STROBE) begin
        if (phase) rd_buf[7:0]  <= bus_data_i;
        else       rd_buf[15:8] <= bus_data_i;
      end
      if (state == HOLD && phase) rsp_q <= rd_buf;
    end
  end

  assign rsp_data_o = rsp_q;
`else
  assign rsp_data_o = '0;
`endif

  assign on_bus = (state == SETUP) || (state == STROBE) ||
                  (state == HOLD);

  assign req_ready_o   = (state == IDLE);
  assign rsp_valid_o   = (state == DONE);
  assign bus_sel_n_o   = (state != STROBE);
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_reg_num_o = reg_q;
  assign bus_bytesel_o = phase;
  assign bus_data_o    = phase ? data_q[7:0] : data_q[15:8];
  assign bus_data_oe_o = on_bus && !rd_nwr_q;

endmodule

// File: tb/tb_bus_host_master.sv
// Directed vector bench for bus_host_master (default and 2/3/2 timing).
module tb_bus_host_master;

`ifdef BUS_HOST_READ_EN
  localparam bit RDEN = 1'b1;
`else
  localparam bit RDEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_rd_nwr;
  logic [3:0]  req_reg_num;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        sel_n, bus_rd_nwr, bytesel, oe;
  logic [3:0]  bus_reg;
  logic [7:0]  bus_dout, bus_din;

  logic        req_valid2, req_ready2, rsp_valid2;
  logic [15:0] rsp_data2;
  logic        sel_n2, bus_rd_nwr2, bytesel2, oe2;
  logic [3:0]  bus_reg2;
  logic [7:0]  bus_dout2, bus_din2;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] last_rsp;

  always #5 clk = ~clk;

  bus_host_master u_dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_rd_nwr_i  (req_rd_nwr),
    .req_reg_num_i (req_reg_num),
    .req_data_i    (req_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .bus_sel_n_o   (sel_n),
    .bus_rd_nwr_o  (bus_rd_nwr),
    .bus_reg_num_o (bus_reg),
    .bus_bytesel_o (bytesel),
    .bus_data_o    (bus_dout),
    .bus_data_oe_o (oe),
    .bus_data_i    (bus_din)
  );

  bus_host_master #(
    .SETUP_CYCLES  (2),
    .STROBE_CYCLES (3),
    .HOLD_CYCLES   (2)
  ) u_dut2 (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .req_valid_i   (req_valid2),
    .req_ready_o   (req_ready2),
    .req_rd_nwr_i  (1'b0),
    .req_reg_num_i (4'h1),
    .req_data_i    (16'h1234),
    .rsp_valid_o   (rsp_valid2),
    .rsp_data_o    (rsp_data2),
    .bus_sel_n_o   (sel_n2),
    .bus_rd_nwr_o  (bus_rd_nwr2),
    .bus_reg_num_o (bus_reg2),
    .bus_bytesel_o (bytesel2),
    .bus_data_o    (bus_dout2),
    .bus_data_oe_o (oe2),
    .bus_data_i    (bus_din2)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  rnum;
    logic [15:0] wdata;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs [5];

  function automatic void chk(input string nm, input int c,
                              input logic [15:0] act,
                              input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc%0d: got %h want %h", nm, c, act, exp);
    end
  endfunction

  // Call at 1 time unit after a posedge with the DUT idle.
  task automatic do_txn(input vec_t v);
    bit   full;
    int   total, k, ph;
    logic [15:0] exp_rsp;
    full  = !(v.rd && !RDEN);
    total = full ? 13 : 1;
    exp_rsp = v.rd ? (RDEN ? {v.hi, v.lo} : 16'h0000) : last_rsp;
    req_valid   = 1'b1;
    req_rd_nwr  = v.rd;
    req_reg_num = v.rnum;
    req_data    = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= total + 1; c++) begin
      bus_din = (c == 5) ? v.hi : (c == 11) ? v.lo : 8'hC3;
      k  = (c - 1) % 6;
      ph = (c - 1) / 6;
      @(negedge clk);
      chk("sel_n", c, 16'(sel_n),
          16'(!(full && c <= 12 && k >= 1 && k <= 4)));
      chk("oe", c, 16'(oe), 16'(full && c <= 12 && !v.rd));
      chk("rsp_valid", c, 16'(rsp_valid), 16'(c == total));
      chk("ready", c, 16'(req_ready), 16'(c == total + 1));
      if (full && c <= 12) begin
        chk("bytesel", c, 16'(bytesel), 16'(ph));
        chk("reg_num", c, 16'(bus_reg), 16'(v.rnum));
        chk("rd_nwr", c, 16'(bus_rd_nwr), 16'(v.rd));
        if (!v.rd)
          chk("wbyte", c, 16'(bus_dout), 16'(ph ? v.wdata[7:0] : v.wdata[15:8]));
      end
      if (c == total) chk("rsp_data", c, rsp_data, exp_rsp);
      @(posedge clk);
      #1;
    end
    last_rsp = exp_rsp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'h3, 16'hA55A, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 4'h5, 16'h0000, 8'h12, 8'h34};
    vecs[2] = '{1'b0, 4'hF, 16'h0001, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 4'h0, 16'hBEEF, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 4'h8, 16'hFF00, 8'h00, 8'h00};

    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_valid2  = 1'b0;
    req_rd_nwr  = 1'b0;
    req_reg_num = 4'h0;
    req_data    = 16'h0;
    bus_din     = 8'h00;
    bus_din2    = 8'h00;
    last_rsp    = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sel_n", 0, 16'(sel_n), 16'h1);
    chk("rst oe", 0, 16'(oe), 16'h0);
    chk("rst rsp_valid", 0, 16'(rsp_valid), 16'h0);
    chk("rst rsp_data", 0, rsp_data, 16'h0);
    chk("rst bus", 0, {7'h0, bus_rd_nwr, bus_reg, bytesel, bus_dout[2:0]}, 16'h0);
    chk("rst dout", 0, 16'(bus_dout), 16'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel ready", 0, 16'(req_ready), 16'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Back-to-back writes; fields changed while busy must be ignored.
    req_valid   = 1'b1;
    req_rd_nwr  = 1'b0;
    req_reg_num = 4'h2;
    req_data    = 16'h0F0F;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c <= 12) chk("b2b reg", c, 16'(bus_reg), 16'h2);
      chk("b2b valid", c, 16'(rsp_valid), 16'(c == 13 || c == 27));
      chk("b2b ready", c, 16'(req_ready), 16'(c == 14 || c == 28));
      chk("b2b oe", c, 16'(oe), 16'(c != 13 && c != 14 && c != 27 && c != 28));
      if (c == 15) chk("b2b reg2", c, 16'(bus_reg), 16'hA);
      if (c == 15) chk("b2b data2", c, 16'(bus_dout), 16'hF0);
      chk("b2b sel_n", c, 16'(sel_n),
          16'(!((c >= 2 && c <= 5) || (c >= 8 && c <= 11) ||
                (c >= 16 && c <= 19) || (c >= 22 && c <= 25))));
      @(posedge clk);
      #1;
      if (c == 2) begin
        req_reg_num = 4'hA;
        req_data    = 16'hF0F0;
      end
      if (c == 14) req_valid = 1'b0;
    end

    // Reset during phase-1 strobe aborts the transfer.
    req_valid   = 1'b1;
    req_reg_num = 4'h6;
    req_data    = 16'h1357;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort pre sel_n", 9, 16'(sel_n), 16'h0);
    chk("abort pre bytesel", 9, 16'(bytesel), 16'h1);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort sel_n", 10, 16'(sel_n), 16'h1);
    chk("abort oe", 10, 16'(oe), 16'h0);
    chk("abort reg", 10, 16'(bus_reg), 16'h0);
    chk("abort rsp_data", 10, rsp_data, 16'h0);
    for (int c = 10; c < 16; c++) begin
      chk("abort valid", c, 16'(rsp_valid), 16'h0);
      chk("abort ready", c, 16'(req_ready), 16'h1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Alternate timing: 2 setup, 3 strobe, 2 hold.
    req_valid2 = 1'b1;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("t2 sel_n", c, 16'(sel_n2),
          16'(!(c <= 14 && ((c - 1) % 7) >= 2 && ((c - 1) % 7) <= 4)));
      chk("t2 valid", c, 16'(rsp_valid2), 16'(c == 15));
      chk("t2 oe", c, 16'(oe2), 16'(c <= 14));
      if (c <= 14) chk("t2 bytesel", c, 16'(bytesel2), 16'(c > 7));
      @(posedge clk);
      #1;
    end
    chk("t2 ready", 17, 16'(req_ready2), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_host_master.md
BUS_HOST_MASTER -- requirements
Module: bus_host_master

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1: cycles that address, bytesel, rd_nwr and data are stable before select asserts.
REQ-002 SHALL have parameter STROBE_CYCLES, default 4: cycles bus_sel_n_o is held low per byte.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1: cycles that address and data are held after select deasserts.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset_n_i  in  1  reset, synchronous, active-low.
REQ-006 req_valid_i  in  1  host request pending.
REQ-007 req_ready_o  out  1  block can accept a request.
REQ-008 req_rd_nwr_i  in  1  1 = register read, 0 = register write.
REQ-009 req_reg_num_i  in  4  target register number.
REQ-010 req_data_i  in  16  write word.
REQ-011 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-012 rsp_data_o  out  16  read word, valid with rsp_valid_o.
REQ-013 bus_sel_n_o  out  1  register select strobe, active-low.
REQ-014 bus_rd_nwr_o  out  1  bus direction.
REQ-015 bus_reg_num_o  out  4  bus register number.
REQ-016 bus_bytesel_o  out  1  0 = even (high) byte, 1 = odd (low) byte.
REQ-017 bus_data_o / bus_data_oe_o  out  8 / 1  write byte and its drive enable.
REQ-018 bus_data_i  in  8  read byte from target.

Function
REQ-019 req_ready_o SHALL be 1 only in IDLE; a request is accepted on a clk edge where req_valid_i and req_ready_o are both 1.
REQ-020 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, DONE; a byte-phase flag (0 = even, 1 = odd) SHALL select the current byte.
REQ-021 On accept, the FSM SHALL go to SETUP with phase 0 and latch rd_nwr, reg_num and data.
REQ-022 SETUP SHALL last SETUP_CYCLES, STROBE SHALL last STROBE_CYCLES, and HOLD SHALL last HOLD_CYCLES.
REQ-023 HOLD in phase 0 SHALL go to SETUP in phase 1; HOLD in phase 1 SHALL go to DONE; DONE SHALL last 1 cycle and then go to IDLE.
REQ-024 bus_sel_n_o SHALL be 0 only in STROBE.
REQ-025 bus_reg_num_o, bus_rd_nwr_o and bus_bytesel_o SHALL equal the latched values and the phase throughout SETUP, STROBE and HOLD, and SHALL stay unchanged in IDLE.
REQ-026 For writes, bus_data_o SHALL be data[15:8] in phase 0 and data[7:0] in phase 1, with bus_data_oe_o = 1 during SETUP, STROBE and HOLD.
REQ-027 bus_data_oe_o SHALL be 0 for reads and in IDLE and DONE.
REQ-028 For reads, bus_data_i SHALL be sampled on the last STROBE cycle, into rsp_data_o[15:8] in phase 0 and rsp_data_o[7:0] in phase 1.
REQ-029 rsp_valid_o SHALL be 1 exactly in DONE, for both reads and writes; rsp_data_o SHALL hold its value until the next read completes.
REQ-030 Latency: with accept at edge 0, the bus cycles SHALL occupy cycles 1..2*(S+T+H) and rsp_valid_o SHALL be in cycle 2*(S+T+H)+1; defaults give cycles 1..12 and rsp_valid_o at cycle 13.
REQ-031 req_ready_o SHALL return to 1 in the cycle after DONE, so back-to-back requests are separated by exactly one DONE cycle.
REQ-032 Request inputs SHALL be ignored while busy; no queueing.
REQ-033 Cycle counters SHALL be 4 bits; parameter values SHALL be limited to SETUP_CYCLES >= 1, HOLD_CYCLES >= 1, 3 <= STROBE_CYCLES <= 15, with an elaboration-time error otherwise.

Reset
REQ-034 reset_n_i = 0 SHALL force, at the next edge: IDLE, bus_sel_n_o = 1, bus_data_oe_o = 0, rsp_valid_o = 0, and all other outputs and rsp_data_o = 0.
REQ-035 A reset mid-transaction SHALL abort with no rsp_valid_o; req_ready_o SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-036 BUS_HOST_READ_EN defined: reads SHALL execute as specified.
REQ-037 BUS_HOST_READ_EN undefined: a read request SHALL be accepted, produce no bus activity, and go directly to DONE with rsp_data_o = 16'h0000; the read sampling logic SHALL be absent.

Structure
REQ-038 Package bus_host_pkg SHALL hold the FSM state enum, the default timing constants and the minimum STROBE_CYCLES constant (3).
REQ-039 Sub-module bus_host_timer SHALL be a loadable 4-bit down-counter with a terminal flag, shared by SETUP, STROBE and HOLD.

Verification
REQ-040 Write reg 3 = 16'hA55A with defaults -> bytesel 0 with data A5 and bytesel 1 with data 5A, bus_sel_n_o low for 4 cycles each, rsp_valid_o at cycle 13.
REQ-041 Read reg 5 with the model driving 8'h12 then 8'h34 -> rsp_data_o = 16'h1234, bus_data_oe_o = 0 throughout.
REQ-042 Two writes with req_valid_i held high -> the second bus SETUP starts 2 cycles after the first rsp_valid_o cycle, with exactly one DONE gap.
REQ-043 reset_n_i low during phase-1 STROBE -> next cycle bus_sel_n_o = 1, no rsp_valid_o, req_ready_o = 1 after release.
REQ-044 STROBE_CYCLES = 3, SETUP_CYCLES = 2, HOLD_CYCLES = 2 -> each byte phase spans 7 cycles and rsp_valid_o is at cycle 15.
REQ-045 Build without BUS_HOST_READ_EN and issue a read -> rsp_valid_o in cycle 1 with data 0 and bus_sel_n_o never low.
